// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register with a valid/ready handshake, a
// synchronous flush that inserts a bubble, and a saturating counter of
// downstream stall cycles. All state updates on the falling edge of clk.
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   : a skid register and a FULL state are added.
//                                  in_ready is registered and has no
//                                  combinational path from out_ready.
//   PIPE_STAGE_SKID_EN undefined : single register with states EMPTY/BUSY.
//                                  in_ready = !out_valid | out_ready.
//
// Ports:
//   clk        in   stage clock (falling-edge active)
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous bubble insert; discards all held entries
//   in_valid   in   upstream bundle valid
//   in_ready   out  stage can accept a bundle this cycle
//   in_data    in   upstream bundle [DATA_W-1:0]
//   out_valid  out  out_data holds a valid bundle
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  registered bundle to next stage [DATA_W-1:0]
//   stall_cnt  out  saturating count of out_valid & !out_ready edges
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned        DATA_W     = 113,
    parameter logic [DATA_W-1:0]  INIT_VALUE = {DATA_W{1'b0}},
    parameter int unsigned        STALL_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                out_valid_r;
    logic [DATA_W-1:0]   main_r;
    logic [STALL_W-1:0]  stall_cnt_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                deliver_s;
    logic                load_in_s;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0]   skid_r;
    logic                in_ready_r;
    logic                load_skid_s;
    logic                load_from_skid_s;

    assign in_ready_s = in_ready_r;
`else
    // Without a skid slot the stage can only take a new bundle when the
    // current one leaves in the same edge (or there is none).
    assign in_ready_s = ~out_valid_r | out_ready;
`endif

    assign accept_s  = in_valid & in_ready_s;
    assign deliver_s = out_valid_r & out_ready;

    // Next-state and load-select decode; flush overrides every transition.
    always_comb begin
        state_nxt_s      = state_r;
        load_in_s        = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_skid_s      = 1'b0;
        load_from_skid_s = 1'b0;
`endif
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_in_s   = 1'b1;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && deliver_s) begin
                        load_in_s   = 1'b1;
                        state_nxt_s = ST_BUSY;
                    end else if (accept_s) begin
`ifdef PIPE_STAGE_SKID_EN
                        // Downstream stalled: park the new bundle behind main.
                        load_skid_s = 1'b1;
                        state_nxt_s = ST_FULL;
`else
                        // Not reachable: in_ready implies out_ready here.
                        state_nxt_s = ST_BUSY;
`endif
                    end else if (deliver_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    // in_ready is low in FULL, so only a deliver can happen.
                    if (deliver_s) begin
                        load_from_skid_s = 1'b1;
                        state_nxt_s      = ST_BUSY;
                    end else begin
                        state_nxt_s      = ST_FULL;
                    end
`else
                    state_nxt_s = ST_EMPTY;
`endif
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register and registered out_valid.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Main data register; holds its last value while EMPTY.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            main_r <= INIT_VALUE;
        end else if (flush) begin
            main_r <= INIT_VALUE;
        end else if (load_in_s) begin
            main_r <= in_data;
`ifdef PIPE_STAGE_SKID_EN
        end else if (load_from_skid_s) begin
            main_r <= skid_r;
`endif
        end else begin
            main_r <= main_r;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid register and registered in_ready (low only while FULL).
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            skid_r     <= INIT_VALUE;
            in_ready_r <= 1'b1;
        end else begin
            if (flush) begin
                skid_r <= INIT_VALUE;
            end else if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
            in_ready_r <= (state_nxt_s != ST_FULL);
        end
    end
`endif

    // Saturating stall counter; flush deliberately leaves it alone.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign stall_cnt = stall_cnt_r;

endmodule
